// File: rtl/priority_enc_pkg.sv
// Shared types and encode helpers for the 4:2 priority encoder and its consumers.
// Latency: pure functions, zero cycles.
// Backpressure: not applicable; no handshake is carried by these definitions.
package priority_enc_pkg;

  // Number of request lines and the width of an encoded index.
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_t;

  // Highest set bit wins; an all-zero request encodes to 0 (qualified by valid).
  function automatic idx_t pe_encode(input req_t d);
    idx_t idx;
    idx = 2'd0;
    if (d[3]) begin
      idx = 2'd3;
    end else if (d[2]) begin
      idx = 2'd2;
    end else if (d[1]) begin
      idx = 2'd1;
    end
    return idx;
  endfunction

  // Any request present.
  function automatic logic pe_valid(input req_t d);
    return |d;
  endfunction

endpackage

// File: rtl/pe_win_counter.sv
// Single saturating win counter with synchronous clear and increment enable.
// Latency: an increment or clear is visible on cnt_o one cycle after the edge.
// Backpressure: none; inc_i is always accepted and ignored once saturated.
module pe_win_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats increment, and the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register; reset discards any accumulated wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/priority_enc_4_2.sv
// 4:2 priority encoder with registered copy and per-index saturating win counters.
// Latency: I/V combinational, I_r/V_r one cycle, cnt shows wins up to the previous edge.
// Backpressure: none; D is sampled every cycle and counters saturate instead of wrapping.
module priority_enc_4_2
  import priority_enc_pkg::*;
#(
  // Win counter width, legal range 2..16.
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D,
  output logic [1:0]       I,
  output logic             V,
  output logic [1:0]       I_r,
  output logic             V_r,
  input  logic             clr,
  input  logic [1:0]       rd_idx,
  output logic [CNT_W-1:0] cnt
);

  idx_t             i_r_q;
  logic             v_r_q;
  logic [NUM_REQ-1:0] win_inc;
  logic [CNT_W-1:0] win_cnt [NUM_REQ];

  // Combinational encode; independent of clock and reset.
  always_comb begin
    I = pe_encode(D);
    V = pe_valid(D);
  end

  // Registered copy of the encoder result, one cycle behind D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r_q <= '0;
      v_r_q <= 1'b0;
    end else begin
      i_r_q <= I;
      v_r_q <= V;
    end
  end

  assign I_r = i_r_q;
  assign V_r = v_r_q;

  // One counter per index; only the current winner increments, and only when valid.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_win
    assign win_inc[k] = V && (I == idx_t'(k));

    pe_win_counter #(
      .CNT_W (CNT_W)
    ) u_win_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (clr),
      .inc_i (win_inc[k]),
      .cnt_o (win_cnt[k])
    );
  end

  // Read port is combinational over counter state only.
  assign cnt = win_cnt[rd_idx];

endmodule

// File: tb/tb_priority_enc_4_2.sv
// Directed self-checking bench for priority_enc_4_2 (CNT_W = 8).
// Latency: inputs driven 1 unit after a rising edge, outputs sampled before the next edge.
// Backpressure: not applicable.
module tb_priority_enc_4_2;

  logic       clk;
  logic       rst_n;
  logic [3:0] D;
  logic [1:0] I;
  logic       V;
  logic [1:0] I_r;
  logic       V_r;
  logic       clr;
  logic [1:0] rd_idx;
  logic [7:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed encoder table for D = 0..15.
  int exp_i [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

  priority_enc_4_2 #(
    .CNT_W (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .D      (D),
    .I      (I),
    .V      (V),
    .I_r    (I_r),
    .V_r    (V_r),
    .clr    (clr),
    .rd_idx (rd_idx),
    .cnt    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Read all four counters through rd_idx; takes 4 time units, no clock edge crossed
  // when called right after tick().
  task automatic check_cnts(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    int exp_arr [4];
    exp_arr = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k);
      #1;
      check($sformatf("%s_cnt%0d", tag, k), int'(cnt), exp_arr[k]);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    D      = 4'd0;
    clr    = 1'b0;
    rd_idx = 2'd0;
    #1;

    // Reset state.
    check("rst_I_r", int'(I_r), 0);
    check("rst_V_r", int'(V_r), 0);
    check_cnts("rst", 0, 0, 0, 0);

    // Full encoder sweep while reset is held: combinational paths stay live.
    for (int d = 0; d < 16; d++) begin
      D = 4'(d);
      #5;
      check($sformatf("sweep_I_d%0d", d), int'(I), exp_i[d]);
      check($sformatf("sweep_V_d%0d", d), int'(V), (d != 0) ? 1 : 0);
    end
    check("rst_hold_V_r", int'(V_r), 0);
    check("rst_hold_I_r", int'(I_r), 0);

    D = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_cnts("post_rst", 0, 0, 0, 0);

    // D=0110 held for one edge: registered copy appears only after that edge.
    D      = 4'b0110;
    rd_idx = 2'd2;
    #1;
    check("pre_edge_I_r", int'(I_r), 0);
    check("pre_edge_V_r", int'(V_r), 0);
    check("pre_edge_cnt2", int'(cnt), 0);
    tick();
    check("post_edge_I_r", int'(I_r), 2);
    check("post_edge_V_r", int'(V_r), 1);
    D = 4'd0;
    check_cnts("one_win", 0, 0, 1, 0);

    // Idle for 10 cycles: counters hold, V_r low.
    for (int c = 0; c < 10; c++) tick();
    check("idle_V_r", int'(V_r), 0);
    check("idle_I_r", int'(I_r), 0);
    check_cnts("idle", 0, 0, 1, 0);

    // D=1000 for 300 cycles: counter 3 saturates at 255, no wrap.
    D      = 4'b1000;
    rd_idx = 2'd3;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 254) check("sat_cnt3_254", int'(cnt), 254);
      if (c == 256) check("sat_cnt3_256", int'(cnt), 255);
    end
    check("sat_I_r", int'(I_r), 3);
    D = 4'b0001;
    check_cnts("sat", 0, 0, 1, 255);

    // Clear wins against a simultaneous increment of counter 0.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_cnts("clr", 0, 0, 0, 0);
    tick();
    check_cnts("after_clr", 1, 0, 0, 0);

    // Build up counter 1, then assert reset mid-cycle.
    D = 4'b0010;
    tick();
    tick();
    tick();
    rd_idx = 2'd1;
    #1;
    check("pre_arst_cnt1", int'(cnt), 3);
    check("pre_arst_V_r", int'(V_r), 1);
    check("pre_arst_I_r", int'(I_r), 1);
    rst_n = 1'b0;
    #1;
    check("arst_cnt1", int'(cnt), 0);
    check("arst_V_r", int'(V_r), 0);
    check("arst_I_r", int'(I_r), 0);
    check("arst_I_live", int'(I), 1);
    check("arst_V_live", int'(V), 1);
    rd_idx = 2'd0;
    #1;
    check("arst_cnt0", int'(cnt), 0);

    D = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_cnts("final", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
